// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin arbiter in front of one SPI flash port,
// with a mode-0 byte shifter and an enforced CS-high gap.
module spi_flash_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] byte_valid,
  input  logic [7:0] byte_data_0,
  input  logic [7:0] byte_data_1,
  output logic [1:0] byte_ready,
  output logic [7:0] rd_data,
  output logic [1:0] rd_valid,
  output logic       busy,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rdy_q, rdy_d;
  logic [1:0]    rdv_q, rdv_d;
  logic          last_q, last_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdd_q, rdd_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tick;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rdy_d   = rdy_q;
    rdv_d   = '0;
    last_d  = last_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdd_d   = rdd_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // last_q names the port served last; on contention the other wins
          if (req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else              gnt_d = req;
          rdy_d   = gnt_d;
          cs_d    = 1'b0;
          state_d = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if ((byte_valid & rdy_q) != 2'b00) begin
          tx_d    = gnt_q[1] ? byte_data_1 : byte_data_0;
          rdy_d   = '0;
          div_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else if ((req & gnt_q) == 2'b00) begin
          cs_d    = 1'b1;
          gnt_d   = '0;
          rdy_d   = '0;
          tx_d    = '0;
          last_d  = gnt_q[1];
          gap_d   = GW'(CS_GAP - 1);
          state_d = RELEASE;
        end
      end
      SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          half_d = half_q + 1'b1;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], spi_miso};
          end else if (half_q == 4'd15) begin
            rdd_d   = rx_q;
            rdv_d   = gnt_q;
            rdy_d   = gnt_q;
            state_d = WAIT_BYTE;
          end else begin
            // mosi is tx_q[7]; shift only on the falling edge
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      RELEASE: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rdy_q   <= '0;
      rdv_q   <= '0;
      last_q  <= 1'b1;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdd_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      rdv_q   <= rdv_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdd_q   <= rdd_d;
      div_q   <= div_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt        = gnt_q;
  assign byte_ready = rdy_q;
  assign rd_valid   = rdv_q;
  assign rd_data    = rdd_q;
  assign busy       = (state_q != IDLE);
  assign spi_cs     = cs_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = tx_q[7];

endmodule
